seg_scan_driver: RTL and testbench

- Downstream display stage. Takes a packed word of 4-bit digit values plus decimal points from the counter/LFSR logic and time-multiplexes them onto one shared 7-segment bus with one-hot digit selects.
- Double-buffered so a mid-frame update never tears the display.
- Applies dead-time blanking between digits to suppress ghosting, and optional leading-zero suppression.

---
 rtl/seg_scan_driver.sv | 157 +++++++++++++++
 tb/tb_seg_scan_driver.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered digits, dead-time blanking between
// slots, optional leading-zero suppression; all outputs registered.
module seg_scan_driver #(
   parameter int          NUM_DIGITS   = 4,
   parameter logic [15:0] SCAN_DIV     = 16'd25,
   parameter logic [15:0] BLANK_CYCLES = 16'd2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lz_blank,
   output logic [6:0]              segment_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_strb
);

   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [NUM_DIGITS-1:0]   r_shadow_dp;
   logic [4*NUM_DIGITS-1:0] r_active;
   logic [NUM_DIGITS-1:0]   r_active_dp;
   logic                    r_pending;
   logic                    r_live;
   logic [15:0]             r_cyc;
   logic [2:0]              r_slot;

   logic                    w_last_cyc;
   logic                    w_last_slot;
   logic                    w_frame_end;
   logic [15:0]             w_cyc_nxt;
   logic [2:0]              w_slot_nxt;
   logic                    w_show;
   logic                    w_strb_nxt;
   logic                    w_zero_run;
   logic [NUM_DIGITS-1:0]   w_lz_mask;
   logic [NUM_DIGITS-1:0]   w_sel_nxt;
   logic [3:0]              w_digit;
   logic                    w_dp_bit;
   logic                    w_blank_dig;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0: seg_decode = 7'h3F;
         4'h1: seg_decode = 7'h06;
         4'h2: seg_decode = 7'h5B;
         4'h3: seg_decode = 7'h4F;
         4'h4: seg_decode = 7'h66;
         4'h5: seg_decode = 7'h6D;
         4'h6: seg_decode = 7'h7D;
         4'h7: seg_decode = 7'h07;
         4'h8: seg_decode = 7'h7F;
         4'h9: seg_decode = 7'h6F;
         4'hA: seg_decode = 7'h77;
         4'hB: seg_decode = 7'h7C;
         4'hC: seg_decode = 7'h39;
         4'hD: seg_decode = 7'h5E;
         4'hE: seg_decode = 7'h79;
         default: seg_decode = 7'h71;
      endcase
   endfunction

   // Outputs are computed for the slot/cycle being entered so they line up with the counters.
   always_comb begin
      w_last_cyc  = (r_cyc == SCAN_DIV - 16'd1);
      w_last_slot = (r_slot == 3'(NUM_DIGITS - 1));
      w_frame_end = w_last_cyc && w_last_slot;
      w_cyc_nxt   = w_last_cyc ? 16'd0 : r_cyc + 16'd1;
      if (w_last_cyc)
         w_slot_nxt = w_last_slot ? 3'd0 : r_slot + 3'd1;
      else
         w_slot_nxt = r_slot;
      w_show     = (w_cyc_nxt >= BLANK_CYCLES);
      w_strb_nxt = (w_cyc_nxt == SCAN_DIV - 16'd1) && (w_slot_nxt == 3'(NUM_DIGITS - 1));

      w_zero_run = 1'b1;
      w_lz_mask  = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         w_zero_run   = w_zero_run & (r_active[4*i +: 4] == 4'd0);
         w_lz_mask[i] = w_zero_run;
      end

      w_digit     = 4'd0;
      w_dp_bit    = 1'b0;
      w_blank_dig = 1'b0;
      w_sel_nxt   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (w_slot_nxt == 3'(i)) begin
            w_digit      = r_active[4*i +: 4];
            w_dp_bit     = r_active_dp[i];
            w_blank_dig  = w_lz_mask[i];
            w_sel_nxt[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cyc  <= 16'd0;
         r_slot <= 3'd0;
      end else begin
         r_cyc  <= w_cyc_nxt;
         r_slot <= w_slot_nxt;
      end
   end

   // r_live keeps the display dark after reset until real data reaches the active buffer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow    <= '0;
         r_shadow_dp <= '0;
         r_active    <= '0;
         r_active_dp <= '0;
         r_pending   <= 1'b0;
         r_live      <= 1'b0;
      end else if (load && w_frame_end) begin
         r_shadow    <= digits_in;
         r_shadow_dp <= dp_in;
         r_active    <= digits_in;
         r_active_dp <= dp_in;
         r_pending   <= 1'b0;
         r_live      <= 1'b1;
      end else if (w_frame_end && r_pending) begin
         r_active    <= r_shadow;
         r_active_dp <= r_shadow_dp;
         r_pending   <= 1'b0;
         r_live      <= 1'b1;
      end else if (load) begin
         r_shadow    <= digits_in;
         r_shadow_dp <= dp_in;
         r_pending   <= 1'b1;
      end
   end

   // A stale active buffer at the frame edge is harmless: the slot entered is always blank.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         segment_out <= 7'd0;
         dp_out      <= 1'b0;
         digit_sel   <= '0;
         frame_strb  <= 1'b0;
      end else begin
         frame_strb <= w_strb_nxt;
         if (w_show) begin
            digit_sel   <= w_sel_nxt;
            segment_out <= (r_live && !(lz_blank && w_blank_dig)) ? seg_decode(w_digit) : 7'd0;
            dp_out      <= r_live & w_dp_bit;
         end else begin
            digit_sel   <= '0;
            segment_out <= 7'd0;
            dp_out      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver (4 digits, 8-cycle slots, 2 blank cycles):
// table of load vectors checked over whole frames, plus buffer/reset corner sequences.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic        lz_blank = 1'b0;
   logic [6:0]  segment_out;
   logic        dp_out;
   logic [3:0]  digit_sel;
   logic        frame_strb;

   int checks = 0;
   int failures = 0;

   seg_scan_driver #(
      .NUM_DIGITS  (4),
      .SCAN_DIV    (16'd8),
      .BLANK_CYCLES(16'd2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .digits_in  (digits_in),
      .dp_in      (dp_in),
      .lz_blank   (lz_blank),
      .segment_out(segment_out),
      .dp_out     (dp_out),
      .digit_sel  (digit_sel),
      .frame_strb (frame_strb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic        lz;
      logic [27:0] segs;   // {slot3, slot2, slot1, slot0}
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic wait_strb(input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         load = 1'b0;
         if (frame_strb) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s frame_strb timeout actual=0 required=1", tag);
      end
   endtask

   // Called with the current sample on a frame_strb cycle; checks the following 32 cycles.
   task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] edp,
                              input int la, input logic [15:0] va,
                              input int lb, input logic [15:0] vb);
      for (int k = 0; k < 32; k++) begin
         int s, c;
         logic [3:0] e_sel;
         logic [6:0] e_seg;
         logic       e_dp;
         @(negedge clk);
         load = 1'b0;
         s = k / 8;
         c = k % 8;
         e_sel = (c < 2) ? 4'b0000 : (4'b0001 << s);
         e_seg = (c < 2) ? 7'h00 : segs[s*7 +: 7];
         e_dp  = (c < 2) ? 1'b0 : edp[s];
         chk($sformatf("%s sel k=%0d", tag, k), 32'(digit_sel), 32'(e_sel));
         chk($sformatf("%s seg k=%0d", tag, k), 32'(segment_out), 32'(e_seg));
         chk($sformatf("%s dp k=%0d", tag, k), 32'(dp_out), 32'(e_dp));
         chk($sformatf("%s strb k=%0d", tag, k), 32'(frame_strb), 32'(k == 31));
         if (k == la) begin
            digits_in = va;
            load = 1'b1;
         end
         if (k == lb) begin
            digits_in = vb;
            load = 1'b1;
         end
      end
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h06, 7'h5B, 7'h4F, 7'h66}};
      vecs[1] = '{16'hABCD, 4'b0100, 1'b0, {7'h77, 7'h7C, 7'h39, 7'h5E}};
      vecs[2] = '{16'h0050, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h6D, 7'h3F}};
      vecs[3] = '{16'h0000, 4'b0000, 1'b1, {7'h00, 7'h00, 7'h00, 7'h3F}};
      vecs[4] = '{16'h0500, 4'b0000, 1'b0, {7'h3F, 7'h6D, 7'h3F, 7'h3F}};
      vecs[5] = '{16'h0500, 4'b0000, 1'b1, {7'h00, 7'h6D, 7'h3F, 7'h3F}};

      #1 reset = 1'b1;
      #11;
      chk("reset sel", 32'(digit_sel), 32'h0);
      chk("reset seg", 32'(segment_out), 32'h0);
      chk("reset dp", 32'(dp_out), 32'h0);
      chk("reset strb", 32'(frame_strb), 32'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      check_frame("post_reset", 28'h0, 4'h0, -1, 16'h0, -1, 16'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         digits_in = vecs[i].digits;
         dp_in     = vecs[i].dp;
         lz_blank  = vecs[i].lz;
         load      = 1'b1;
         wait_strb($sformatf("vec%0d", i));
         check_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].dp, -1, 16'h0, -1, 16'h0);
      end

      // Tear-free update, last-load-wins, then a load coincident with frame_strb.
      lz_blank = 1'b0;
      dp_in    = 4'h0;
      @(negedge clk);
      digits_in = 16'h2222;
      load      = 1'b1;
      wait_strb("tear_setup");
      check_frame("tear_2222", {4{7'h5B}}, 4'h0, 11, 16'h1111, -1, 16'h0);
      check_frame("tear_1111", {4{7'h06}}, 4'h0, 5, 16'h3333, 20, 16'h4444);
      check_frame("last_wins", {4{7'h66}}, 4'h0, 31, 16'h9999, -1, 16'h0);
      check_frame("coincident", {4{7'h6F}}, 4'h0, -1, 16'h0, -1, 16'h0);
      check_frame("coinc_hold", {4{7'h6F}}, 4'h0, -1, 16'h0, -1, 16'h0);

      // Asynchronous reset during a show cycle of slot 2.
      wait_strb("async_setup");
      repeat (20) @(negedge clk);
      chk("pre_rst sel", 32'(digit_sel), 32'h4);
      chk("pre_rst seg", 32'(segment_out), 32'h6F);
      #2 reset = 1'b1;
      #1;
      chk("async sel", 32'(digit_sel), 32'h0);
      chk("async seg", 32'(segment_out), 32'h0);
      chk("async dp", 32'(dp_out), 32'h0);
      chk("async strb", 32'(frame_strb), 32'h0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      check_frame("rst_blank", 28'h0, 4'h0, -1, 16'h0, -1, 16'h0);
      @(negedge clk);
      digits_in = 16'h1234;
      load      = 1'b1;
      wait_strb("rst_reload");
      check_frame("rst_reload", {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'h0, -1, 16'h0, -1, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
